// File: rtl/clkrst_gen_pkg.sv
// Shared types for the clock/reset generator: sequencer states and reset-cause codes.
// Latency: none (declarations only).
// Backpressure: none.
package clkrst_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    HOLD      = 2'b01,
    RUN       = 2'b10
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_PLL = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  // Number of clk_in cycles per sys_clk half period.
  function automatic int half_div(input int osc, input int cpu);
    return (osc / cpu) / 2;
  endfunction

endpackage

// File: rtl/clkrst_gen_sync2.sv
// Two-flop synchronizer for a single level signal into the clk_in domain.
// Latency: 2 clk_in cycles from d to q.
// Backpressure: none; q simply follows d after the delay.
module sync2 (
  input  logic clk_in,
  input  logic b_reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages clear asynchronously on reset.
  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clkrst_gen.sv
// CPU clock divider plus reset sequencer driven by PLL lock, button and software requests.
// Latency: reset release 2 clk_in cycles; lock changes seen after 2 cycles; sys_res moves on sys_clk rises.
// Backpressure: none; sw_reset_req is sampled only on sys_clk rise edges while running.
module clkrst_gen
  import clkrst_gen_pkg::*;
#(
  parameter int OSC_CLOCK  = 24000000,
  parameter int CPU_CLOCK  = 3000000,
  parameter int RESET_HOLD = 4
) (
  input  logic       clk_in,
  input  logic       b_reset,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  output logic       sys_clk,
  output logic       sys_clk_rise,
  output logic       sys_res,
  output logic [1:0] res_cause
);

  // OSC_CLOCK/CPU_CLOCK must be an even integer >= 2, so P is at least 1.
  localparam int P    = half_div(OSC_CLOCK, CPU_CLOCK);
  localparam int CW   = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] LAST = CW'(P - 1);

  logic          rst_sync;
  logic          lock_sync;
  logic [CW-1:0] div_cnt;
  logic          rise_nxt;
  state_t        state;
  logic [7:0]    hold_cnt;

  // Reset asserts asynchronously but releases only after two clk_in edges.
  sync2 u_rst_sync (
    .clk_in  (clk_in),
    .b_reset (b_reset),
    .d       (1'b1),
    .q       (rst_sync)
  );

  // PLL lock comes from another clock region and is retimed before use.
  sync2 u_lock_sync (
    .clk_in  (clk_in),
    .b_reset (rst_sync),
    .d       (pll_locked),
    .q       (lock_sync)
  );

  // True on the edge at which sys_clk goes high; the sequencer steps on this
  // same edge so sys_res changes together with the sys_clk_rise pulse.
  assign rise_nxt = (div_cnt == LAST) && !sys_clk;

  // Free-running divider: toggles sys_clk every P clk_in cycles in every state.
  always_ff @(posedge clk_in or negedge rst_sync) begin
    if (!rst_sync) begin
      div_cnt      <= '0;
      sys_clk      <= 1'b0;
      sys_clk_rise <= 1'b0;
    end else begin
      sys_clk_rise <= rise_nxt;
      if (div_cnt == LAST) begin
        div_cnt <= '0;
        sys_clk <= ~sys_clk;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
    end
  end

  // Reset sequencer: lock loss wins on any cycle; everything else steps on sys_clk rises.
  always_ff @(posedge clk_in or negedge rst_sync) begin
    if (!rst_sync) begin
      state     <= WAIT_LOCK;
      hold_cnt  <= '0;
      sys_res   <= 1'b1;
      res_cause <= CAUSE_POR;
    end else if (!lock_sync) begin
      // Only a drop out of HOLD/RUN is a PLL reset; waiting at power-on keeps the old cause.
      if (state != WAIT_LOCK) res_cause <= CAUSE_PLL;
      state    <= WAIT_LOCK;
      hold_cnt <= '0;
      if (rise_nxt) sys_res <= 1'b1;
    end else if (rise_nxt) begin
      case (state)
        WAIT_LOCK: begin
          state    <= HOLD;
          hold_cnt <= 8'(RESET_HOLD);
          sys_res  <= 1'b1;
        end
        HOLD: begin
          if (hold_cnt == 8'd0) begin
            state   <= RUN;
            sys_res <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
            sys_res  <= 1'b1;
          end
        end
        RUN: begin
          if (sw_reset_req) begin
            state     <= HOLD;
            hold_cnt  <= 8'(RESET_HOLD);
            res_cause <= CAUSE_SW;
            sys_res   <= 1'b1;
          end else begin
            sys_res <= 1'b0;
          end
        end
        default: begin
          state   <= WAIT_LOCK;
          sys_res <= 1'b1;
        end
      endcase
    end
  end

endmodule
